// File: rtl/popcount_window_stats_pkg.sv
// popcount_window_stats_pkg: shared types and defaults for the popcount window statistics block.
// POPCOUNT_STATS_AVG_EN adds the avg field to the record.
package popcount_pkg;
  localparam int CNT_W_DEF  = 4;
  localparam int WINDOW_DEF = 8;
  localparam int SUM_W_DEF  = CNT_W_DEF + $clog2(WINDOW_DEF);
  typedef logic [CNT_W_DEF-1:0] cnt_t;
  typedef struct packed {
    logic [SUM_W_DEF-1:0] sum;
    cnt_t                 min;
    cnt_t                 max;
`ifdef POPCOUNT_STATS_AVG_EN
    cnt_t                 avg;
`endif
  } stats_rec_t;
  typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_t;
endpackage

// File: rtl/popcount_window_stats_if.sv
// popcount_window_stats_if: popcount input stream plus valid/ready statistics record.
// POPCOUNT_STATS_AVG_EN adds avg_o.
interface popcount_window_stats_if #(
  parameter int CNT_W  = 4,
  parameter int WINDOW = 8
);
  localparam int SW = CNT_W + $clog2(WINDOW);
  logic [CNT_W-1:0] cnt_i;
  logic             cnt_val_i;
  logic             flush_i;
  logic             stats_ready_i;
  logic             stats_val_o;
  logic [SW-1:0]    sum_o;
  logic [CNT_W-1:0] min_o;
  logic [CNT_W-1:0] max_o;
  logic             overrun_o;
`ifdef POPCOUNT_STATS_AVG_EN
  logic [CNT_W-1:0] avg_o;
`endif
  modport master (
    output cnt_i, cnt_val_i, flush_i, stats_ready_i,
`ifdef POPCOUNT_STATS_AVG_EN
    input  avg_o,
`endif
    input  stats_val_o, sum_o, min_o, max_o, overrun_o
  );
  modport slave (
    input  cnt_i, cnt_val_i, flush_i, stats_ready_i,
`ifdef POPCOUNT_STATS_AVG_EN
    output avg_o,
`endif
    output stats_val_o, sum_o, min_o, max_o, overrun_o
  );
endinterface

// File: rtl/popcount_window_stats_acc.sv
// popcount_window_acc: per-window sum/min/max accumulators; pulses rec_load_o with the merged record.
// POPCOUNT_STATS_AVG_EN fills the avg field.
module popcount_window_acc
  import popcount_pkg::*;
#(
  parameter int  CNT_W  = CNT_W_DEF,
  parameter int  WINDOW = WINDOW_DEF,
  parameter type rec_t  = stats_rec_t
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic             cnt_val_i,
  input  logic             flush_i,
  output logic             rec_load_o,
  output rec_t             rec_o
);
  localparam int IW = $clog2(WINDOW);
  localparam int SW = CNT_W + IW;
  logic [IW-1:0]    r_idx;
  logic [SW-1:0]    r_sum, w_sum;
  logic [CNT_W-1:0] r_min, r_max, w_min, w_max;
  logic             w_last;
  always_comb begin
    w_sum      = r_sum + SW'(cnt_i);
    w_min      = (cnt_i < r_min) ? cnt_i : r_min;
    w_max      = (cnt_i > r_max) ? cnt_i : r_max;
    w_last     = cnt_val_i & ~flush_i & (r_idx == IW'(WINDOW - 1));
    rec_load_o = w_last;
    rec_o      = '0;
    rec_o.sum  = w_sum;
    rec_o.min  = w_min;
    rec_o.max  = w_max;
`ifdef POPCOUNT_STATS_AVG_EN
    rec_o.avg  = w_sum[SW-1:IW];
`endif
  end
  // The window's last sample re-arms the accumulators so the next cycle can start a new window.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i || flush_i || w_last) begin
      r_idx <= '0;
      r_sum <= '0;
      r_min <= '1;
      r_max <= '0;
    end else if (cnt_val_i) begin
      r_idx <= r_idx + 1'b1;
      r_sum <= w_sum;
      r_min <= w_min;
      r_max <= w_max;
    end
  end
endmodule

// File: rtl/popcount_window_stats.sv
// popcount_window_stats: windowed sum/min/max of popcount results held on a valid/ready record.
// POPCOUNT_STATS_AVG_EN adds a truncated average output.
module popcount_window_stats
  import popcount_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int WINDOW = WINDOW_DEF
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  popcount_window_stats_if.slave  bus
);
  localparam int SW = CNT_W + $clog2(WINDOW);
  typedef struct packed {
    logic [SW-1:0]    sum;
    logic [CNT_W-1:0] min;
    logic [CNT_W-1:0] max;
`ifdef POPCOUNT_STATS_AVG_EN
    logic [CNT_W-1:0] avg;
`endif
  } rec_t;
  out_state_t r_state, w_state_nxt;
  rec_t       r_rec, w_rec;
  logic       w_load, r_overrun;
  popcount_window_acc #(.CNT_W(CNT_W), .WINDOW(WINDOW), .rec_t(rec_t)) u_acc (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .cnt_i      (bus.cnt_i),
    .cnt_val_i  (bus.cnt_val_i),
    .flush_i    (bus.flush_i),
    .rec_load_o (w_load),
    .rec_o      (w_rec)
  );
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= OUT_EMPTY;
    else       r_state <= w_state_nxt;
  end
  always_comb begin
    w_state_nxt = w_load ? OUT_FULL :
                  (r_state == OUT_FULL && bus.stats_ready_i) ? OUT_EMPTY : r_state;
  end
  // A load onto an untaken record replaces it and latches the overrun flag until reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rec     <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_load) r_rec <= w_rec;
      if (w_load && r_state == OUT_FULL && !bus.stats_ready_i) r_overrun <= 1'b1;
    end
  end
  assign bus.stats_val_o = (r_state == OUT_FULL);
  assign bus.sum_o       = r_rec.sum;
  assign bus.min_o       = r_rec.min;
  assign bus.max_o       = r_rec.max;
  assign bus.overrun_o   = r_overrun;
`ifdef POPCOUNT_STATS_AVG_EN
  assign bus.avg_o       = r_rec.avg;
`endif
endmodule
